control_multiciclo: RTL and testbench

Multi-cycle control unit that sequences the processor datapath: instruction fetch, decode, execute, memory access and register write-back. It replaces the single-cycle control path and drives the IR/PC write enables, ALU operand select, write-back select and a variable-latency memory handshake. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/control_multiciclo.sv | 157 +++++++++++++++
 tb/tb_control_multiciclo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// Multi-cycle control unit: sequences fetch, decode, execute, memory and
// write-back, with a bounded memory handshake and a retired-instruction count.
module control_multiciclo #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_dir_sel_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             reg_we_o,
    output logic             sel_inm_o,
    output logic             sel_wb_o,
    output logic [2:0]       estado_o,
    output logic             ilegal_o,
    output logic             error_bus_o,
    output logic [CNT_W-1:0] retiradas_o
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIM = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        INICIO = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } estado_t;

    typedef enum logic [1:0] {
        CL_I = 2'd0,
        CL_R = 2'd1,
        CL_L = 2'd2,
        CL_S = 2'd3
    } clase_t;

    estado_t          state_q, state_d;
    clase_t           clase_q, clase_d;
    logic [WW-1:0]    espera_q, espera_d;
    logic             ilegal_q, ilegal_d;
    logic             error_q, error_d;
    logic             retira;
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= INICIO;
            clase_q  <= CL_I;
            espera_q <= '0;
            ilegal_q <= 1'b0;
            error_q  <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            clase_q  <= clase_d;
            espera_q <= espera_d;
            ilegal_q <= ilegal_d;
            error_q  <= error_d;
            if (retira) ret_q <= ret_q + CNT_W'(1);
        end
    end

    // Wait counter defaults to zero, so any state change clears it
    always_comb begin
        state_d       = state_q;
        clase_d       = clase_q;
        espera_d      = '0;
        ilegal_d      = ilegal_q;
        error_d       = error_q;
        retira        = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_dir_sel_o = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        reg_we_o      = 1'b0;
        sel_inm_o     = 1'b0;
        sel_wb_o      = 1'b0;
        unique case (state_q)
            INICIO: state_d = FETCH;
            FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = DECODE;
                end else if (espera_q == LIM) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end else begin
                    espera_d = espera_q + WW'(1);
                end
            end
            DECODE: begin
                state_d = EXEC;
                case (opcode_i)
                    7'b0010011: clase_d = CL_I;
                    7'b0110011: clase_d = CL_R;
                    7'b0000011: clase_d = CL_L;
                    7'b0100011: clase_d = CL_S;
                    default: begin
                        ilegal_d = 1'b1;
                        state_d  = HALT;
                    end
                endcase
            end
            EXEC: begin
                sel_inm_o = (clase_q != CL_R);
                if (clase_q == CL_L || clase_q == CL_S) state_d = MEM;
                else state_d = WB;
            end
            MEM: begin
                mem_req_o     = 1'b1;
                mem_dir_sel_o = 1'b1;
                sel_inm_o     = 1'b1;
                mem_we_o      = (clase_q == CL_S);
                if (mem_ready_i) begin
                    if (clase_q == CL_S) begin
                        pc_we_o = 1'b1;
                        retira  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (espera_q == LIM) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end else begin
                    espera_d = espera_q + WW'(1);
                end
            end
            WB: begin
                reg_we_o  = 1'b1;
                pc_we_o   = 1'b1;
                sel_wb_o  = (clase_q == CL_L);
                sel_inm_o = (clase_q != CL_R);
                retira    = 1'b1;
                state_d   = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    assign estado_o    = state_q;
    assign ilegal_o    = ilegal_q;
    assign error_bus_o = error_q;
    assign retiradas_o = ret_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// its expected per-cycle trace; a monitor compares the DUT every cycle.
module tb_control_multiciclo;

    localparam int TO = 16;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef struct packed {
        logic [2:0]  st;
        logic        req, we, dir, irw, pcw, regw, inm, wb, il, eb;
        logic [31:0] ret;
    } exp_t;

    typedef struct packed {
        logic       rn;
        logic       rdy;
        logic [6:0] op;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, mem_we_o, mem_dir_sel_o, ir_we_o;
    logic        pc_we_o, reg_we_o, sel_inm_o, sel_wb_o;
    logic [2:0]  estado_o;
    logic        ilegal_o, error_bus_o;
    logic [31:0] retiradas_o;

    control_multiciclo #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .opcode_i(opcode_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_dir_sel_o(mem_dir_sel_o),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .reg_we_o(reg_we_o),
        .sel_inm_o(sel_inm_o), .sel_wb_o(sel_wb_o), .estado_o(estado_o),
        .ilegal_o(ilegal_o), .error_bus_o(error_bus_o),
        .retiradas_o(retiradas_o)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    bit    started = 0;
    bit    done = 0;

    logic [31:0] m_ret = '0;
    bit          m_il = 0;
    bit          m_eb = 0;

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st  = st;
        e.il  = m_il;
        e.eb  = m_eb;
        e.ret = m_ret;
        return e;
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic void push(input exp_t e, input logic rdy,
                                 input logic [6:0] op, input logic rn);
        stim_t s;
        s.rn  = rn;
        s.rdy = rdy;
        s.op  = op;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endfunction

    function automatic void reset_seq(input int n);
        m_ret = '0;
        m_il  = 0;
        m_eb  = 0;
        for (int i = 0; i < n; i++)
            push(blank(3'd0), 1'($urandom), junk(), 1'b0);
        push(blank(3'd0), 1'($urandom), junk(), 1'b1);
    endfunction

    function automatic void halt_seq(input int n);
        for (int i = 0; i < n; i++)
            push(blank(3'd6), 1'($urandom), junk(), 1'b1);
    endfunction

    // fd/md: idle cycles before ready in FETCH/MEM; cut>0 stops after cut MEM cycles
    function automatic void instr(input logic [6:0] op, input int fd,
                                  input int md, input int cut);
        exp_t e;
        bit   rdy, is_l, is_s, is_r;
        is_l = (op == OP_L);
        is_s = (op == OP_S);
        is_r = (op == OP_R);
        for (int k = 0; ; k++) begin
            rdy   = (k == fd);
            e     = blank(3'd1);
            e.req = 1'b1;
            e.irw = rdy;
            push(e, rdy, junk(), 1'b1);
            if (rdy) break;
            if (k == TO - 1) begin
                m_eb = 1;
                return;
            end
        end
        push(blank(3'd2), 1'($urandom), op, 1'b1);
        if (!(is_l || is_s || is_r || op == OP_I)) begin
            m_il = 1;
            return;
        end
        e     = blank(3'd3);
        e.inm = !is_r;
        push(e, 1'($urandom), junk(), 1'b1);
        if (is_l || is_s) begin
            for (int k = 0; ; k++) begin
                rdy   = (k == md);
                e     = blank(3'd4);
                e.req = 1'b1;
                e.dir = 1'b1;
                e.inm = 1'b1;
                e.we  = is_s;
                e.pcw = is_s && rdy;
                push(e, rdy, junk(), 1'b1);
                if (cut > 0 && k == cut - 1) return;
                if (rdy) break;
                if (k == TO - 1) begin
                    m_eb = 1;
                    return;
                end
            end
            if (is_s) begin
                m_ret = m_ret + 1;
                return;
            end
        end
        e      = blank(3'd5);
        e.regw = 1'b1;
        e.pcw  = 1'b1;
        e.wb   = is_l;
        e.inm  = !is_r;
        push(e, 1'($urandom), junk(), 1'b1);
        m_ret = m_ret + 1;
    endfunction

    function automatic void build();
        logic [6:0] ops[4];
        ops[0] = OP_I;
        ops[1] = OP_R;
        ops[2] = OP_L;
        ops[3] = OP_S;
        reset_seq(3);
        for (int i = 0; i < 3; i++) instr(OP_I, 0, 0, 0);
        instr(OP_L, 0, 3, 0);
        instr(OP_S, 0, 0, 0);
        instr(OP_R, 0, 0, 0);
        for (int i = 0; i < 25; i++)
            instr(ops[$urandom_range(3)], $urandom_range(4),
                  $urandom_range(4), 0);
        instr(OP_I, TO - 1, 0, 0);
        instr(OP_L, 2, TO - 1, 0);
        instr(OP_S, 1, TO, 0);
        halt_seq(4);
        reset_seq(2);
        instr(OP_R, 1, 0, 0);
        instr(OP_B, 0, 0, 0);
        halt_seq(5);
        reset_seq(1);
        instr(OP_I, TO, 0, 0);
        halt_seq(3);
        reset_seq(2);
        instr(OP_S, 0, 0, 0);
        instr(OP_L, 0, 8, 3);
        reset_seq(2);
        instr(OP_L, 0, 0, 0);
    endfunction

    initial begin : driver
        stim_t s;
        build();
        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            rst_ni      = s.rn;
            mem_ready_i = s.rdy;
            opcode_i    = s.op;
            started     = 1;
        end
        @(posedge clk);
        #1;
        done = 1;
    end

    initial begin : monitor
        exp_t e, g;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (started && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.st   = estado_o;
                g.req  = mem_req_o;
                g.we   = mem_we_o;
                g.dir  = mem_dir_sel_o;
                g.irw  = ir_we_o;
                g.pcw  = pc_we_o;
                g.regw = reg_we_o;
                g.inm  = sel_inm_o;
                g.wb   = sel_wb_o;
                g.il   = ilegal_o;
                g.eb   = error_bus_o;
                g.ret  = retiradas_o;
                n_checks++;
                if (g === e) n_pass++;
                else $display("FAIL cyc%0d got=%h exp=%h", cyc, g, e);
                cyc++;
            end
        end
    end

    initial begin : finisher
        wait (done);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover got=%0d exp=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=done");
        $fatal(1, "watchdog expired");
    end

endmodule
